mc_ctrl: RTL

- Multicycle control FSM for the MIPS datapath: PC, IM, instruction register, RF, EXT, ALU and DM, with the GPRSel, BSel, WDSel and NPC muxes.
- Replaces the single-cycle decoder: each instruction runs over 3–5+ states, sharing one ALU for address, arithmetic and compare.
- Drives the datapath's existing control encodings, plus a DM request/ready handshake for variable-latency memory.

---
 rtl/mc_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the MIPS datapath, with a DM request/ready
// handshake bounded by a 4-bit wait counter. Outputs are decoded from state.
module mc_ctrl #(
  parameter int unsigned DM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       dm_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic       dm_req,
  output logic       BSel,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [1:0] EXTOp,
  output logic [1:0] ALUOp,
  output logic [1:0] GPRSel,
  output logic [3:0] state_o,
  output logic       instr_done,
  output logic       illegal,
  output logic       dm_timeout
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,  S_DCD  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
    S_MWB   = 4'd4,  S_MWR  = 4'd5,  S_EXE = 4'd6,  S_RWB = 4'd7,
    S_IEXE  = 4'd8,  S_IWB  = 4'd9,  S_BR  = 4'd10, S_JMP = 4'd11,
    S_JAL   = 4'd12, S_JR   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [3:0] L_TMO    = 4'(DM_TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_inc;
  logic       w_in_wait;
  logic       w_tmo_hit;

  logic       w_pcwr, w_irwr, w_rfwr, w_dmwr, w_req, w_bsel;
  logic [1:0] w_wdsel, w_npcop, w_extop, w_aluop, w_gprsel;
  logic       w_done, w_illegal, w_tmo;

  function automatic logic [1:0] alu_of_funct(input logic [5:0] fn);
    logic [1:0] res;
    case (fn)
      6'h21:   res = 2'b00;
      6'h23:   res = 2'b01;
      6'h25:   res = 2'b10;
      6'h2A:   res = 2'b11;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // Returns {EXTOp, ALUOp} for the immediate-ALU instructions.
  function automatic logic [3:0] imm_ctrl(input logic [5:0] op);
    logic [3:0] res;
    case (op)
      6'h0D:   res = 4'b00_10;
      6'h09:   res = 4'b01_00;
      6'h0F:   res = 4'b10_00;
      default: res = 4'b00_00;
    endcase
    return res;
  endfunction

  assign w_in_wait  = (r_state == S_MRD) || (r_state == S_MWR);
  assign w_wait_inc = r_wait_cnt + 4'd1;
  assign w_tmo_hit  = w_in_wait && !dm_ready && (L_TMO != 4'd0) && (w_wait_inc == L_TMO);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // DM wait counter: counts stalled cycles, clears on any exit from the wait states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_in_wait && !dm_ready && !w_tmo_hit) begin
      r_wait_cnt <= w_wait_inc;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next    = S_FETCH;
    w_pcwr    = 1'b0;
    w_irwr    = 1'b0;
    w_rfwr    = 1'b0;
    w_dmwr    = 1'b0;
    w_req     = 1'b0;
    w_bsel    = 1'b0;
    w_wdsel   = 2'b00;
    w_npcop   = 2'b00;
    w_extop   = 2'b00;
    w_aluop   = 2'b00;
    w_gprsel  = 2'b00;
    w_done    = 1'b0;
    w_illegal = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwr = 1'b1;
        w_pcwr = 1'b1;
        w_next = S_DCD;
      end
      S_DCD: begin
        case (OP)
          OP_RTYPE: begin
            case (Funct)
              6'h21, 6'h23, 6'h25, 6'h2A: w_next = S_EXE;
              6'h08:                      w_next = S_JR;
              default: begin
                w_illegal = 1'b1;
                w_next    = S_FETCH;
              end
            endcase
          end
          OP_LW, OP_SW:        w_next = S_MA;
          6'h0D, 6'h09, 6'h0F: w_next = S_IEXE;
          6'h04:               w_next = S_BR;
          6'h02:               w_next = S_JMP;
          6'h03:               w_next = S_JAL;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MA: begin
        w_bsel  = 1'b1;
        w_extop = 2'b01;
        if (OP == OP_LW) begin
          w_next = S_MRD;
        end else if (OP == OP_SW) begin
          w_next = S_MWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MRD, S_MWR: begin
        w_bsel  = 1'b1;
        w_extop = 2'b01;
        w_req   = 1'b1;
        w_dmwr  = (r_state == S_MWR);
        if (dm_ready) begin
          w_done = (r_state == S_MWR);
          w_next = (r_state == S_MRD) ? S_MWB : S_FETCH;
        end else if (w_tmo_hit) begin
          w_tmo  = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = r_state;
        end
      end
      S_MWB: begin
        w_rfwr   = 1'b1;
        w_gprsel = 2'b01;
        w_wdsel  = 2'b01;
        w_done   = 1'b1;
      end
      S_EXE: begin
        w_aluop = alu_of_funct(Funct);
        w_next  = S_RWB;
      end
      S_RWB: begin
        w_aluop = alu_of_funct(Funct);
        w_rfwr  = 1'b1;
        w_done  = 1'b1;
      end
      S_IEXE: begin
        w_bsel             = 1'b1;
        {w_extop, w_aluop} = imm_ctrl(OP);
        w_next             = S_IWB;
      end
      S_IWB: begin
        w_bsel             = 1'b1;
        {w_extop, w_aluop} = imm_ctrl(OP);
        w_rfwr             = 1'b1;
        w_gprsel           = 2'b01;
        w_done             = 1'b1;
      end
      S_BR: begin
        w_aluop = 2'b01;
        w_extop = 2'b01;
        w_npcop = 2'b01;
        w_pcwr  = Zero;
        w_done  = 1'b1;
      end
      S_JMP: begin
        w_pcwr  = 1'b1;
        w_npcop = 2'b10;
        w_done  = 1'b1;
      end
      S_JAL: begin
        w_pcwr   = 1'b1;
        w_npcop  = 2'b10;
        w_rfwr   = 1'b1;
        w_gprsel = 2'b10;
        w_wdsel  = 2'b10;
        w_done   = 1'b1;
      end
      S_JR: begin
        w_pcwr  = 1'b1;
        w_npcop = 2'b11;
        w_done  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low immediately, so FETCH's enables cannot leak out.
  assign PCWr       = rst_n & w_pcwr;
  assign IRWr       = rst_n & w_irwr;
  assign RFWr       = rst_n & w_rfwr;
  assign DMWr       = rst_n & w_dmwr;
  assign dm_req     = rst_n & w_req;
  assign BSel       = rst_n & w_bsel;
  assign WDSel      = rst_n ? w_wdsel  : 2'b00;
  assign NPCOp      = rst_n ? w_npcop  : 2'b00;
  assign EXTOp      = rst_n ? w_extop  : 2'b00;
  assign ALUOp      = rst_n ? w_aluop  : 2'b00;
  assign GPRSel     = rst_n ? w_gprsel : 2'b00;
  assign state_o    = rst_n ? 4'(r_state) : 4'd0;
  assign instr_done = rst_n & w_done;
  assign illegal    = rst_n & w_illegal;
  assign dm_timeout = rst_n & w_tmo;

endmodule
